// File: rtl/stab_init_gen_pkg.sv
// Shared definitions for the stabilizer-tableau front end: Pauli literal
// encoding, basis-mode codes and the initialiser FSM state type.
package qcm_stab_pkg;

  localparam logic [1:0] LIT_I = 2'b00;
  localparam logic [1:0] LIT_Z = 2'b01;
  localparam logic [1:0] LIT_X = 2'b10;
  localparam logic [1:0] LIT_Y = 2'b11;

  localparam logic MODE_Z = 1'b0;
  localparam logic MODE_X = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Diagonal literal of a product-state stabilizer row for the given basis.
  function automatic logic [1:0] basis_lit(input logic mode);
    return (mode == MODE_X) ? LIT_X : LIT_Z;
  endfunction

endpackage

// File: rtl/stab_init_gen_if.sv
// Control and row-stream bundle between the tableau initialiser (master)
// and its controller / stabilizer-matrix loader (slave).
interface stab_init_gen_if #(
  parameter int num_qubit = 3,
  parameter int IDX_W     = (num_qubit > 1) ? $clog2(num_qubit) : 1
) ();

  logic                 start;
  logic                 abort;
  logic                 mode;
  logic [num_qubit-1:0] basis_bits;
  logic                 ready_in;
  logic [1:0]           literals_out [0:num_qubit-1];
  logic                 phase_out;
  logic                 valid_out;
  logic [IDX_W-1:0]     row_idx_out;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, mode, basis_bits, ready_in,
    output literals_out, phase_out, valid_out, row_idx_out, busy, done
  );

  modport slave (
    output start, abort, mode, basis_bits, ready_in,
    input  literals_out, phase_out, valid_out, row_idx_out, busy, done
  );

endinterface

// File: rtl/stab_init_gen_row_fmt.sv
// Combinational formatter for stabilizer row k of a product state:
// one basis literal on the diagonal, identity elsewhere, sign from bits_q[k].
module stab_row_fmt
  import qcm_stab_pkg::*;
#(
  parameter int num_qubit = 3,
  parameter int IDX_W     = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic [IDX_W-1:0]     k,
  input  logic                 mode_q,
  input  logic [num_qubit-1:0] bits_q,
  output logic [1:0]           literals [0:num_qubit-1],
  output logic                 phase
);

  always_comb begin
    for (int i = 0; i < num_qubit; i++) begin
      literals[i] = (IDX_W'(i) == k) ? basis_lit(mode_q) : LIT_I;
    end
    phase = bits_q[k];
  end

endmodule

// File: rtl/stab_init_gen.sv
// Product-state stabilizer-tableau initialiser: on start, streams num_qubit
// rows over a valid/ready handshake with abort and backpressure support.
module stab_init_gen
  import qcm_stab_pkg::*;
#(
  parameter int num_qubit = 3,
  parameter int IDX_W     = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic           clk,
  input  logic           rst_new,
  stab_init_gen_if.master bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(num_qubit - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     k_q, k_d;
  logic                 mode_q, mode_d;
  logic [num_qubit-1:0] bits_q, bits_d;

  logic [1:0]           lits_q [0:num_qubit-1];
  logic                 phase_q;
  logic                 valid_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q;
  logic                 done_q;

  logic [1:0]           row_lits [0:num_qubit-1];
  logic                 row_phase;
  logic                 xfer;
  logic                 emit_d;

  assign xfer   = valid_q && bus.ready_in;
  assign emit_d = (state_d == ST_EMIT);

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= MODE_Z;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      bits_q  <= bits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    bits_d  = bits_q;
    case (state_q)
      ST_IDLE: begin
        // abort outranks start so a controller can cancel a pending request
        if (!bus.abort && bus.start) begin
          state_d = ST_EMIT;
          k_d     = '0;
          mode_d  = bus.mode;
          bits_d  = bus.basis_bits;
        end
      end
      ST_EMIT: begin
        if (xfer && (k_q != LAST)) begin
          k_d = k_q + IDX_W'(1);
        end
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (xfer && (k_q == LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The row is formatted from next-cycle state so outputs can be registered
  // without adding a cycle of latency.
  stab_row_fmt #(
    .num_qubit (num_qubit),
    .IDX_W     (IDX_W)
  ) u_row_fmt (
    .k        (k_d),
    .mode_q   (mode_d),
    .bits_q   (bits_d),
    .literals (row_lits),
    .phase    (row_phase)
  );

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      for (int i = 0; i < num_qubit; i++) lits_q[i] <= LIT_I;
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      for (int i = 0; i < num_qubit; i++) lits_q[i] <= emit_d ? row_lits[i] : LIT_I;
      phase_q <= emit_d && row_phase;
      valid_q <= emit_d;
      idx_q   <= emit_d ? k_d : '0;
      busy_q  <= emit_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.literals_out = lits_q;
  assign bus.phase_out    = phase_q;
  assign bus.valid_out    = valid_q;
  assign bus.row_idx_out  = idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: doc/stab_init_gen.md
Name: stab_init_gen

Overview:
- Parametrised stabilizer-tableau initialiser.
- On a start request it streams num_qubit stabilizer rows describing a product state. Two bases are supported:
  - computational basis |b>: Z-basis;
  - Hadamard basis |+/->: X-basis.
- Per-qubit sign comes from a bit vector.
- Sits at the front of the emulation datapath, feeding the stabilizer-matrix loader over a valid/ready stream.
- Supports backpressure, abort and repeated runs without reset.

Parameters:
- num_qubit, 3: number of qubits, equal to the number of rows emitted and the literal columns per row.
- IDX_W, $clog2(num_qubit) (min 1): width of the row index output.

Ports:
- clk  input  1  clock
- rst_new  input  1  reset, asynchronous, active-high
- start  input  1  request a new initialisation run (sampled in IDLE only)
- abort  input  1  synchronous abort of the current run
- mode  input  1  0 = Z-basis (literal Z), 1 = X-basis (literal X)
- basis_bits  input  num_qubit  per-qubit sign; bit k=1 selects |1> or |->
- ready_in  input  1  downstream accepts a row this cycle
- literals_out  output  2 x num_qubit (unpacked [0:num_qubit-1])  row literals; encoding 00=I, 01=Z, 10=X, 11=Y
- phase_out  output  1  row sign (1 = negative)
- valid_out  output  1  row on outputs is valid
- row_idx_out  output  IDX_W  index k of the current row
- busy  output  1  run in progress (EMIT state)
- done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- All outputs are registered.
- Reset values: literals_out all 00, phase_out 0, valid_out 0, row_idx_out 0, busy 0, done 0, state IDLE, mode/bits latches 0.
- FSM states are IDLE, EMIT, DONE.
- IDLE:
  - start=1 latches mode and basis_bits into internal registers, clears the row counter and moves to EMIT.
  - The first row appears with valid_out=1 on the cycle after start is sampled (latency 1).
- EMIT, row k:
  - literals_out[k] = 01 if mode_q=0, else 10.
  - All other columns are 00.
  - phase_out = bits_q[k].
  - row_idx_out = k.
  - valid_out = 1, busy = 1.
- Handshake:
  - A transfer occurs on a cycle with valid_out && ready_in.
  - On transfer with k < num_qubit-1: k increments and the next row is presented the next cycle (back-to-back rate of 1 row/cycle).
  - With ready_in=0, all outputs hold stable. valid_out must not drop without a transfer except on abort or reset.
- Last row: a transfer at k = num_qubit-1 moves to DONE. Next cycle: valid_out=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start while busy or in DONE is ignored; there is no queuing.
- mode and basis_bits are sampled only at start; later changes have no effect on the run.
- abort:
  - In EMIT, abort=1 returns to IDLE next cycle with valid_out=0 and no done pulse.
  - If abort and a transfer coincide, the transfer counts but the run still ends without done.
  - In IDLE, abort has priority over start.
- rst_new asserted mid-run immediately forces the reset values; no partial-row glitch is tolerated after release.
- num_qubit=1: a single row, with row_idx_out width 1.
- The row counter never wraps; it is bounded by the num_qubit-1 compare.

Decomposition:
- Shared package qcm_stab_pkg:
  - literal encoding constants LIT_I, LIT_Z, LIT_X, LIT_Y (2-bit);
  - mode constants MODE_Z, MODE_X;
  - the FSM state typedef.
- Literal/phase row formatting for index k is natural as a small combinational sub-module, stab_row_fmt (inputs: k, mode_q, bits_q; outputs: literals, phase).
- The FSM and handshake stay in stab_init_gen.

Test Plan:
1. num_qubit=3, mode=0, basis_bits=000, ready_in=1, start at cycle 0 -> cycles 1..3 show rows (01,00,00), (00,01,00), (00,00,01) with phase 0 and row_idx 0,1,2; done=1 at cycle 4; busy=0 at cycle 4.
2. mode=1, basis_bits=101 -> literals use 10 on the diagonal; phases 1,0,1 for rows 0,1,2.
3. Backpressure: ready_in=0 for 2 cycles while row 1 is presented -> row 1 (00,01,00, idx 1) held unchanged for 3 cycles; total run 5 cycles of valid; done after row 2 transfers.
4. start pulsed again during EMIT with different mode/bits -> ignored; the stream matches the first request; a new start after done launches a correct second run.
5. abort asserted while row 1 is valid -> valid_out=0 next cycle, no done pulse, busy=0; a following start produces a full 3-row run from idx 0.
6. rst_new asserted while row 1 is valid -> all outputs 0 immediately (asynchronously); after release the block is IDLE and ignores stale start history.
